// File: rtl/stk_pipe_pkg.sv
// Shared types and constants for the stack head-pointer command front-end.
package stk_pipe_pkg;

    localparam int N    = 1024;
    localparam int W    = 10;
    localparam int ID_W = $clog2(N);

    localparam logic [W-1:0] NULL_PTR = {W{1'b1}};

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Commands that read the SRAM and therefore return a response.
    function automatic logic op_reads(input op_e op);
        return (op == OP_READ) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/stk_pipe_head_init_seq.sv
// Post-reset sweep sequencer: walks addresses 0..N-1, one per cycle, then stops.
module stk_pipe_head_init_seq
    import stk_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            arst_n,
    output logic [ID_W-1:0] o_addr,
    output logic            o_last,
    output logic            o_busy
);

    logic [ID_W-1:0] r_cnt;
    logic            r_done;

    assign o_addr = r_cnt;
    assign o_last = !r_done && (r_cnt == ID_W'(N - 1));
    assign o_busy = !r_done;

    // Advance the sweep address each cycle and latch done after the last entry.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_cnt <= r_cnt + ID_W'(1);
            if (r_cnt == ID_W'(N - 1)) begin
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stk_pipe_head_ctl.sv
// Command front-end for the per-stack head-pointer SRAM.
// READ/WRITE/SWAP commands share the single SRAM port; a SWAP takes the read
// on its accept cycle and the write on the following cycle.
// Optional feature: define STK_PIPE_HEAD_CTL_INIT_EN to sweep every entry to
// NULL_PTR after reset before commands are accepted.
//
// Handshakes: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both high; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both high. o_rsp_valid and its payload hold
// steady until the response transfers.
module stk_pipe_head_ctl
    import stk_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            arst_n,
    input  logic            i_cmd_valid,
    input  logic [1:0]      i_cmd_op,
    input  logic [ID_W-1:0] i_cmd_id,
    input  logic [W-1:0]    i_cmd_ptr,
    output logic            o_cmd_ready,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [ID_W-1:0] o_rsp_id,
    output logic [W-1:0]    o_rsp_head,
    output logic            o_rsp_empty,
    output logic            o_init_busy,
    output logic [ID_W-1:0] o_sram_addr,
    output logic [W-1:0]    o_sram_din,
    output logic            o_sram_ce,
    output logic            o_sram_oe,
    input  logic [W-1:0]    i_sram_dout
);

    state_e          r_state;
    logic            r_valid;       // stage R holds a response
    logic            r_first;       // stage R is in its first cycle (dout live)
    logic            r_swap_first;  // first cycle of a SWAP: write-back slot
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    r_ptr;
    logic [W-1:0]    r_hold;        // dout captured when the first cycle stalls

    op_e             w_op;
    logic            w_run;
    logic            w_cmd_ready;
    logic            w_accept;
    logic            w_load_r;
    logic            w_rsp_fire;
    logic [W-1:0]    w_head;

    logic [ID_W-1:0] w_init_addr;
    logic            w_init_last;
    logic            w_init_busy;

`ifdef STK_PIPE_HEAD_CTL_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;

    stk_pipe_head_init_seq u_init_seq (
        .clk    (clk),
        .arst_n (arst_n),
        .o_addr (w_init_addr),
        .o_last (w_init_last),
        .o_busy (w_init_busy)
    );
`else
    localparam state_e RESET_STATE = ST_RUN;

    assign w_init_addr = '0;
    assign w_init_last = 1'b0;
    assign w_init_busy = 1'b0;
`endif

    // Reset is folded in so that nothing is accepted or driven while it is held.
    assign w_op        = op_e'(i_cmd_op);
    assign w_run       = arst_n && (r_state == ST_RUN);
    assign w_cmd_ready = w_run && (!r_valid || (!r_swap_first && i_rsp_ready));
    assign w_accept    = i_cmd_valid && w_cmd_ready;
    assign w_load_r    = w_accept && op_reads(w_op);
    assign w_rsp_fire  = r_valid && i_rsp_ready;

    assign w_head      = !r_valid ? '0 : (r_first ? i_sram_dout : r_hold);

    assign o_cmd_ready = w_cmd_ready;
    assign o_rsp_valid = r_valid;
    assign o_rsp_id    = r_id;
    assign o_rsp_head  = w_head;
    assign o_rsp_empty = r_valid && (w_head == NULL_PTR);
    assign o_init_busy = w_init_busy;

    // SRAM port arbitration: sweep, then SWAP write-back, then the new command.
    always_comb begin
        o_sram_ce   = 1'b0;
        o_sram_oe   = 1'b0;
        o_sram_addr = '0;
        o_sram_din  = '0;
        if (r_state == ST_INIT) begin
            if (arst_n) begin
                o_sram_ce   = 1'b1;
                o_sram_addr = w_init_addr;
                o_sram_din  = NULL_PTR;
            end
        end else if (r_swap_first) begin
            o_sram_ce   = 1'b1;
            o_sram_addr = r_id;
            o_sram_din  = r_ptr;
        end else if (w_accept) begin
            case (w_op)
                OP_READ, OP_SWAP: begin
                    o_sram_ce   = 1'b1;
                    o_sram_oe   = 1'b1;
                    o_sram_addr = i_cmd_id;
                end
                OP_WRITE: begin
                    o_sram_ce   = 1'b1;
                    o_sram_addr = i_cmd_id;
                    o_sram_din  = i_cmd_ptr;
                end
                default: begin
                end
            endcase
        end
    end

    // Mode FSM plus response stage R (load on accept, retire on handshake).
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= RESET_STATE;
            r_valid      <= 1'b0;
            r_first      <= 1'b0;
            r_swap_first <= 1'b0;
            r_id         <= '0;
            r_ptr        <= '0;
            r_hold       <= '0;
        end else begin
            if ((r_state == ST_INIT) && w_init_last) begin
                r_state <= ST_RUN;
            end
            if (r_first && !i_rsp_ready) begin
                r_hold <= i_sram_dout;
            end
            if (w_load_r) begin
                r_valid      <= 1'b1;
                r_first      <= 1'b1;
                r_swap_first <= (w_op == OP_SWAP);
                r_id         <= i_cmd_id;
                r_ptr        <= i_cmd_ptr;
            end else begin
                r_first      <= 1'b0;
                r_swap_first <= 1'b0;
                if (w_rsp_fire) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stk_pipe_head_ctl.sv
// Bench for stk_pipe_head_ctl: SRAM model, random and directed commands,
// reference memory updated in program order, scoreboard monitor on responses.
// Builds with or without STK_PIPE_HEAD_CTL_INIT_EN.
`timescale 1ns/1ps
module tb_stk_pipe_head_ctl;
    import stk_pipe_pkg::*;

`ifdef STK_PIPE_HEAD_CTL_INIT_EN
    localparam int  EXP_BUSY      = N;
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam int  EXP_BUSY      = 0;
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            arst_n = 1'b0;
    logic            i_cmd_valid = 1'b0;
    logic [1:0]      i_cmd_op = 2'b00;
    logic [ID_W-1:0] i_cmd_id = '0;
    logic [W-1:0]    i_cmd_ptr = '0;
    logic            i_rsp_ready = 1'b0;
    logic [W-1:0]    i_sram_dout;
    logic            o_cmd_ready, o_rsp_valid, o_rsp_empty, o_init_busy;
    logic [ID_W-1:0] o_rsp_id, o_sram_addr;
    logic [W-1:0]    o_rsp_head, o_sram_din;
    logic            o_sram_ce, o_sram_oe;

    stk_pipe_head_ctl dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_id    (i_cmd_id),
        .i_cmd_ptr   (i_cmd_ptr),
        .o_cmd_ready (o_cmd_ready),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_head  (o_rsp_head),
        .o_rsp_empty (o_rsp_empty),
        .o_init_busy (o_init_busy),
        .o_sram_addr (o_sram_addr),
        .o_sram_din  (o_sram_din),
        .o_sram_ce   (o_sram_ce),
        .o_sram_oe   (o_sram_oe),
        .i_sram_dout (i_sram_dout)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    logic        rdy_rand = 1'b0;
    logic        rdy_val  = 1'b1;

    typedef struct packed {
        logic [31:0]     stamp;
        logic            swap;
        logic [ID_W-1:0] id;
        logic [W-1:0]    head;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] sram_mem [N];
    logic [W-1:0] ref_mem  [N];

    function automatic logic [W-1:0] init_val(input int i);
`ifdef STK_PIPE_HEAD_CTL_INIT_EN
        return W'(i * 113 + 7);
`else
        return (i % 4 == 1) ? NULL_PTR : W'(i * 37 + 3);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port SRAM, 1-cycle read latency; dout is junk when no read ran.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < N; i++) sram_mem[i] <= init_val(i);
        end else if (o_sram_ce && o_sram_oe) begin
            i_sram_dout <= sram_mem[o_sram_addr];
        end else begin
            i_sram_dout <= W'($urandom);
            if (o_sram_ce) sram_mem[o_sram_addr] <= o_sram_din;
        end
    end

    // Response-side ready, changed mid-cycle.
    always @(posedge clk) begin
        #2;
        i_rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // ---------------- monitor / scoreboard ----------------
    logic            prev_valid = 1'b0;
    logic            prev_fire  = 1'b0;
    logic [ID_W-1:0] prev_id    = '0;
    logic [W-1:0]    prev_head  = '0;
    int              sweep_idx  = 0;
    exp_t            mon_e;

    always @(negedge clk) begin
        if (!arst_n) begin
            prev_valid = 1'b0;
            prev_fire  = 1'b0;
            sweep_idx  = 0;
        end else begin
            if (o_init_busy) begin
                check("init_ce", o_sram_ce, 1);
                check("init_oe", o_sram_oe, 0);
                check("init_addr", o_sram_addr, sweep_idx);
                check("init_din", o_sram_din, NULL_PTR);
                sweep_idx++;
            end
            if (o_rsp_valid) begin
                if (!prev_valid || prev_fire) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got id %0h head %0h expected no response", o_rsp_id, o_rsp_head);
                    end else begin
                        mon_e = exp_q[0];
                        check("rsp_id", o_rsp_id, mon_e.id);
                        check("rsp_head", o_rsp_head, mon_e.head);
                        check("rsp_empty", o_rsp_empty, mon_e.head == NULL_PTR);
                        check("rsp_latency", cyc, mon_e.stamp + 1);
                        if (mon_e.swap) check("swap_ready_low", o_cmd_ready, 0);
                    end
                end else begin
                    check("hold_id", o_rsp_id, prev_id);
                    check("hold_head", o_rsp_head, prev_head);
                end
                if (!i_rsp_ready) check("stall_ready_low", o_cmd_ready, 0);
                else if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (!o_init_busy && !i_cmd_valid) begin
                check("idle_ce", o_sram_ce, 0);
            end
            prev_valid = o_rsp_valid;
            prev_fire  = o_rsp_valid && i_rsp_ready;
            prev_id    = o_rsp_id;
            prev_head  = o_rsp_head;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input op_e op, input logic [ID_W-1:0] id,
                            input logic [W-1:0] ptr, output int waits);
        bit   done;
        exp_t e;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_id    = id;
        i_cmd_ptr   = ptr;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (o_cmd_ready) begin
                done    = 1;
                e.stamp = cyc;
                e.swap  = (op == OP_SWAP);
                e.id    = id;
                e.head  = ref_mem[id];
                case (op)
                    OP_READ, OP_SWAP: begin
                        check("acc_rd_ce", {o_sram_ce, o_sram_oe}, 2'b11);
                        check("acc_rd_addr", o_sram_addr, id);
                        exp_q.push_back(e);
                        if (op == OP_SWAP) ref_mem[id] = ptr;
                    end
                    OP_WRITE: begin
                        check("acc_wr_ce", {o_sram_ce, o_sram_oe}, 2'b10);
                        check("acc_wr_addr", o_sram_addr, id);
                        check("acc_wr_din", o_sram_din, ptr);
                        ref_mem[id] = ptr;
                    end
                    default: check("acc_rsvd_ce", o_sram_ce, 0);
                endcase
            end else begin
                waits++;
                if (waits > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cmd_accept_timeout: got ready 0 for %0d cycles expected accept", waits);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_reset(input bit first);
        int busy;
        arst_n      = 1'b0;
        i_cmd_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_id", o_rsp_id, 0);
        check("rst_rsp_head", o_rsp_head, 0);
        check("rst_rsp_empty", o_rsp_empty, 0);
        check("rst_sram_ce", o_sram_ce, 0);
        check("rst_sram_oe", o_sram_oe, 0);
        check("rst_sram_addr", o_sram_addr, 0);
        check("rst_sram_din", o_sram_din, 0);
        check("rst_init_busy", o_init_busy, EXP_BUSY_RST);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        busy = 0;
        forever begin
            @(negedge clk);
            if (o_cmd_ready) break;
            busy++;
            if (busy > N + 100) break;
        end
        check("init_ready_low_cycles", busy, EXP_BUSY);
        check("init_write_count", sweep_idx, EXP_BUSY);
`ifdef STK_PIPE_HEAD_CTL_INIT_EN
        for (int i = 0; i < N; i++) ref_mem[i] = NULL_PTR;
`else
        if (first) for (int i = 0; i < N; i++) ref_mem[i] = init_val(i);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int b;
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        b = 0;
        while (exp_q.size() != 0 && b < 50) begin
            @(posedge clk);
            b++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int           w;
        logic [W-1:0] old20;

        do_reset(1);

        // Fresh entry reads as empty.
        send_cmd(OP_READ, 10'd5, '0, w);
        drain();

        // Back-to-back reads: one per cycle.
        for (int i = 0; i < 8; i++) begin
            send_cmd(OP_READ, ID_W'(i), '0, w);
            check("b2b_wait", w, 0);
        end
        drain();

        // SWAP then READ: READ waits one cycle, sees the new head.
        send_cmd(OP_SWAP, 10'd3, 10'h012, w);
        send_cmd(OP_READ, 10'd3, '0, w);
        check("swap_next_wait", w, 1);
        drain();

        // Response stall for four cycles while dout wanders.
        rdy_val = 1'b0;
        send_cmd(OP_READ, 10'd9, '0, w);
        repeat (4) @(posedge clk);
        #1;
        rdy_val = 1'b1;
        send_cmd(OP_READ, 10'd10, '0, w);
        drain();

        // WRITE right after READ of the same id.
        send_cmd(OP_READ, 10'd7, '0, w);
        send_cmd(OP_WRITE, 10'd7, 10'h055, w);
        check("write_after_read_wait", w, 0);
        send_cmd(OP_READ, 10'd7, '0, w);
        send_cmd(OP_RSVD, 10'd7, 10'h000, w);
        send_cmd(OP_READ, 10'd7, '0, w);
        drain();

        // Random traffic with random response back-pressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int              r;
            op_e             op;
            logic [ID_W-1:0] id;
            logic [W-1:0]    p;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? OP_READ : (r < 6) ? OP_WRITE : (r < 9) ? OP_SWAP : OP_RSVD;
            id = ($urandom_range(0, 7) == 0) ? ID_W'($urandom) : ID_W'($urandom_range(0, 15));
            p  = ($urandom_range(0, 3) == 0) ? NULL_PTR : W'($urandom);
            send_cmd(op, id, p, w);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset asserted during a SWAP: its write-back is lost.
        old20 = ref_mem[20];
        send_cmd(OP_SWAP, 10'd20, 10'h0AB, w);
        do_reset(0);
`ifndef STK_PIPE_HEAD_CTL_INIT_EN
        ref_mem[20] = old20;
`endif
        send_cmd(OP_READ, 10'd20, '0, w);
        send_cmd(OP_READ, 10'd7, '0, w);
        send_cmd(OP_READ, 10'd3, '0, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
